// File: rtl/bit_serial_pkg.sv
// bit_serial_pkg
//   Shared constants for the bit-serial arithmetic blocks.
//   - ST_IDLE / ST_RUN / ST_DONE : FSM state encodings
//   - state_t                    : enum built on those encodings
//   - BSA_WIDTH_DEF              : default operand width
package bit_serial_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int BSA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell
//   Combinational 1-bit full adder.
//   Ports:
//     a, b, cin : input bits
//     s         : sum bit   (a ^ b ^ cin)
//     cout      : carry out (majority of a, b, cin)
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// bit_serial_adder
//   LSB-first bit-serial adder: sum = a + b over WIDTH cycles using a single
//   full-adder cell and a carry flop, behind a start/busy/done handshake.
//   Ports:
//     clk       : rising-edge clock
//     rst_n     : asynchronous active-low reset
//     start     : begin an addition (only honoured in IDLE)
//     a, b      : operands, captured on the edge that accepts start
//     sum       : WIDTH-bit result (registered)
//     carry_out : bit WIDTH of a+b (registered)
//     busy      : high while bits are being processed
//     done      : one-cycle pulse, sum/carry_out valid
module bit_serial_adder
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = BSA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic             fa_s, fa_co;
  logic             last_bit;

  // Single adder cell working on the current LSBs and the running carry.
  full_adder_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (c),
    .s    (fa_s),
    .cout (fa_co)
  );

  assign last_bit = (cnt == CNT_LAST);

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_RUN;
      S_RUN:   if (last_bit) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State register plus flag outputs. busy/done are registered from the
  // next state so they line up with the state flop with no output decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n == S_RUN);
      done  <= (state_n == S_DONE);
    end
  end

  // Datapath: operand shifters, carry flop, bit counter, result shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
          end
        end
        S_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          c    <= fa_co;
          cnt  <= cnt + 1'b1;
          // New bit enters at the MSB; after WIDTH shifts bit 0 lands in sum[0].
          sum  <= {fa_s, sum[WIDTH-1:1]};
          if (last_bit) carry_out <= fa_co;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] sum;
  logic         carry_out, busy, done;

  int total = 0;
  int bad   = 0;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Stimulus only: present start with operands off-edge, let the next edge
  // capture, then count cycles until done (bounded). Returns 1ns after the
  // edge that raised done.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        output logic [W-1:0] s, output logic co,
                        output int lat, output int busy_n);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_n = busy ? 1 : 0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_n++;
    end
    s  = sum;
    co = carry_out;
  endtask

  task automatic go_idle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h exp=00", sum); end
    total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL reset_co got=%b exp=0", carry_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [W-1:0] s; logic co; int lat, bn;
    go_idle();
    run_op(8'h35, 8'h4A, s, co, lat, bn);
    total++; if (s !== 8'h7F) begin bad++; $display("FAIL basic_sum got=%h exp=7f", s); end
    total++; if (co !== 1'b0) begin bad++; $display("FAIL basic_co got=%b exp=0", co); end
    total++; if (lat !== 8) begin bad++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    total++; if (bn !== 8) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=8", bn); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b exp=0", done); end
    total++; if (sum !== 8'h7F) begin bad++; $display("FAIL basic_sum_hold got=%h exp=7f", sum); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] s; logic co; int lat, bn;
    go_idle();
    run_op(8'hFF, 8'h01, s, co, lat, bn);
    total++; if (s !== 8'h00) begin bad++; $display("FAIL ovf1_sum got=%h exp=00", s); end
    total++; if (co !== 1'b1) begin bad++; $display("FAIL ovf1_co got=%b exp=1", co); end
    go_idle();
    run_op(8'hFF, 8'hFF, s, co, lat, bn);
    total++; if (s !== 8'hFE) begin bad++; $display("FAIL ovf2_sum got=%h exp=fe", s); end
    total++; if (co !== 1'b1) begin bad++; $display("FAIL ovf2_co got=%b exp=1", co); end
  endtask

  task automatic test_inverse();
    logic [W-1:0] s; logic co; int lat, bn;
    // {a, b, expected sum}; upper nibbles never overlap so no carry out.
    logic [W-1:0] tv [4][3] = '{
      '{8'hA0, 8'h50, 8'hF0},
      '{8'hA0, 8'h51, 8'hF1},
      '{8'hA1, 8'h50, 8'hF1},
      '{8'hA1, 8'h51, 8'hF2}
    };
    logic [W-1:0] av, bv;
    go_idle();
    run_op(8'h7F, 8'h01, s, co, lat, bn);
    total++; if (s !== 8'h80) begin bad++; $display("FAIL inv_sum got=%h exp=80", s); end
    total++; if (co !== 1'b0) begin bad++; $display("FAIL inv_co got=%b exp=0", co); end
    for (int i = 0; i < 4; i++) begin
      go_idle();
      av = tv[i][0]; bv = tv[i][1];
      run_op(av, bv, s, co, lat, bn);
      total++; if (s[0] !== (av[0] ^ bv[0])) begin bad++; $display("FAIL lsb_%0d got=%b exp=%b", i, s[0], av[0] ^ bv[0]); end
      total++; if (s !== tv[i][2] || co !== 1'b0) begin bad++; $display("FAIL lsb_full_%0d got=%h/%b exp=%h/0", i, s, co, tv[i][2]); end
    end
  endtask

  task automatic test_start_busy();
    int ndone = 0;
    logic [W-1:0] s0 = 'x;
    go_idle();
    a = 8'h10; b = 8'h20; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a = 8'h11; b = 8'h22; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (done) begin
        ndone++;
        if (ndone == 1) s0 = sum;
      end
      @(posedge clk); #1;
    end
    total++; if (ndone !== 1) begin bad++; $display("FAIL busy_start_dones got=%0d exp=1", ndone); end
    total++; if (s0 !== 8'h30) begin bad++; $display("FAIL busy_start_sum got=%h exp=30", s0); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] s; logic co; int lat, bn;
    go_idle();
    a = 8'hC3; b = 8'h3C; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (sum !== 8'h00 || carry_out !== 1'b0) begin bad++; $display("FAIL midrst_out got=%h/%b exp=00/0", sum, carry_out); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midrst_flags got=%b/%b exp=0/0", busy, done); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_idle got=%b/%b exp=0/0", busy, done); end
    run_op(8'h01, 8'h02, s, co, lat, bn);
    total++; if (s !== 8'h03 || co !== 1'b0) begin bad++; $display("FAIL midrst_after got=%h/%b exp=03/0", s, co); end
  endtask

  task automatic test_operand_change();
    int lat = 0;
    go_idle();
    a = 8'h0F; b = 8'h01; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    a = 8'hAA; b = 8'h55;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    total++; if (sum !== 8'h10 || carry_out !== 1'b0) begin bad++; $display("FAIL opchg got=%h/%b exp=10/0", sum, carry_out); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s; logic co; int lat, bn;
    go_idle();
    run_op(8'h12, 8'h34, s, co, lat, bn);
    total++; if (s !== 8'h46) begin bad++; $display("FAIL b2b_first got=%h exp=46", s); end
    // One edge moves DONE -> IDLE; start is then high for the first IDLE edge.
    @(posedge clk); #1;
    run_op(8'h80, 8'h81, s, co, lat, bn);
    total++; if (s !== 8'h01 || co !== 1'b1) begin bad++; $display("FAIL b2b_second got=%h/%b exp=01/1", s, co); end
    total++; if (lat !== 8) begin bad++; $display("FAIL b2b_latency got=%0d exp=8", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_inverse();
    test_start_busy();
    test_reset_mid();
    test_operand_change();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
